audio_mixer: RTL and testbench
==============================

AUDIO_MIXER -- requirements
Module: audio_mixer

Interface
REQ-001 SHALL have parameter NSRC, default 4, number of mixed sources (1..16).
REQ-002 SHALL have parameter DW, default 8, sample and DAC width in bits (4..16).
REQ-003 SHALL have parameter VW, default 4, per-source volume width in bits (2..8).
REQ-004 SHALL have one clock and an asynchronous, active-high reset, with ports named clock and reset.
REQ-005 Port list:
- clock  in  1  system clock.
- reset  in  1  asynchronous reset, active high.
- src  in  NSRC*DW  unsigned source samples; source i occupies bits [i*DW +: DW].
- vol_l  in  NSRC*VW  left volume per source, same packing as src.
- vol_r  in  NSRC*VW  right volume per source, same packing as src.
- mute  in  NSRC  bit i high forces source i to zero contribution.
- lmix  out  DW  latched left mix.
- rmix  out  DW  latched right mix.
- strobe  out  1  one-cycle pulse when lmix/rmix update.
- clip  out  2  [0] left, [1] right; high for the frame whose mix saturated.
- audio  out  2  [0] left, [1] right; 1-bit sigma-delta DAC outputs.

Function
REQ-006 SHALL run a slot counter idx stepping 0..NSRC-1, +1 per clock, wrapping to 0.
REQ-007 Slot k SHALL sample only src[k], vol_l[k], vol_r[k] and mute[k] in that clock; changes to other sources mid-frame SHALL NOT affect the current slot.
REQ-008 Per slot: p_l = mute[k] ? 0 : src[k]*vol_l[k]; p_r likewise; unsigned, DW+VW bits.
REQ-009 Accumulators SHALL be DW+VW+ceil(log2 NSRC) bits wide and SHALL never overflow.
REQ-010 At idx=0 the accumulator SHALL load p (no separate clear cycle); at other slots it SHALL add p.
REQ-011 Gain SHALL be vol/2^(VW-1): mix = (sum of p) >> (VW-1); vol=2^(VW-1) is unity and vol=0 is silence.
REQ-012 If the shifted sum exceeds 2^DW-1, mix SHALL saturate to 2^DW-1 and the matching clip bit SHALL be set.
REQ-013 In the clock where idx=NSRC-1, lmix/rmix/clip SHALL register the final value including the last slot; strobe SHALL be high for that one clock only.
REQ-014 lmix/rmix/clip SHALL hold between strobes; strobe period SHALL be exactly NSRC clocks.
REQ-015 Latency: a source change sampled in slot k SHALL appear on lmix/rmix with the strobe ending that frame.
REQ-016 NSRC=1: idx SHALL stay 0 and strobe SHALL be high every clock.
REQ-017 Each DAC SHALL be first-order: dacacc (DW+1 bits) <= dacacc[DW-1:0] + mix, evaluated every clock.
REQ-018 audio[n] SHALL equal registered dacacc[DW]; ones-density over 2^DW clocks SHALL equal mix exactly for constant mix.
REQ-019 DACs SHALL use the latched lmix/rmix, never the partial accumulators.

Reset
REQ-020 While reset is high: idx, accumulators, lmix, rmix, clip, strobe, dacacc and audio SHALL be 0.
REQ-021 Reset mid-frame SHALL discard the partial frame; after release, slot 0 SHALL be processed on the first clock and the first strobe SHALL occur on the NSRC-th clock.
REQ-022 No output SHALL glitch high in the clock after reset release.

Verification (NSRC=4, DW=8, VW=4)
REQ-023 Assert reset for 3 clocks, then hold src=0 -> lmix=rmix=0, clip=0, audio=00 throughout; strobe every 4 clocks.
REQ-024 src0=0x80, vol_l0=8, vol_r0=0, all other vols 0 -> lmix=0x80, rmix=0x00 at the first strobe; clip=00.
REQ-025 All src=0xFF, all vol=15 -> lmix=rmix=0xFF, clip=11; then set all vol=1 -> next frame lmix=rmix=0x7F (4*255*1>>3=127), clip=00.
REQ-026 Setup of REQ-024 plus mute[0]=1 -> lmix=0x00 on the next strobe; releasing mute restores 0x80 one frame later.
REQ-027 Constant lmix=0x40 -> audio[0] high for exactly 64 of every 256 consecutive clocks; lmix=0xFF -> high for 255 of every 256.
REQ-028 Assert reset while idx=2, release -> all outputs 0 immediately; first strobe on the 4th clock after release, with values from the new frame only.

Source files
------------

// File: rtl/audio_mixer.sv
// Multi-source stereo mixer: time-multiplexes one multiply-accumulate per
// channel across NSRC slots, latches the saturated mix once per frame and
// drives a first-order sigma-delta DAC per channel from the latched mix.
module audio_mixer #(
  parameter int NSRC = 4,
  parameter int DW   = 8,
  parameter int VW   = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NSRC*DW-1:0] src,
  input  logic [NSRC*VW-1:0] vol_l,
  input  logic [NSRC*VW-1:0] vol_r,
  input  logic [NSRC-1:0]    mute,
  output logic [DW-1:0]      lmix,
  output logic [DW-1:0]      rmix,
  output logic               strobe,
  output logic [1:0]         clip,
  output logic [1:0]         audio
);

  localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int PW = DW + VW;
  // Room for NSRC full-scale products, so the running sum can never wrap.
  localparam int AW = DW + VW + $clog2(NSRC);
  localparam logic [IW-1:0] LAST = IW'(NSRC - 1);
  localparam logic [AW-1:0] FULL = AW'((1 << DW) - 1);

  logic [IW-1:0] idx;
  logic [DW-1:0] cur_src;
  logic [VW-1:0] cur_vl;
  logic [VW-1:0] cur_vr;
  logic          cur_mute;
  logic [PW-1:0] p_l;
  logic [PW-1:0] p_r;
  logic [AW-1:0] acc_l;
  logic [AW-1:0] acc_r;
  logic [AW-1:0] sum_l;
  logic [AW-1:0] sum_r;
  logic [AW-1:0] shf_l;
  logic [AW-1:0] shf_r;
  logic          sat_l;
  logic          sat_r;
  logic [DW-1:0] mix_l;
  logic [DW-1:0] mix_r;
  logic [DW:0]   dac_l;
  logic [DW:0]   dac_r;

  // Select only the current slot's source, volumes and mute bit.
  always_comb begin
    cur_src  = '0;
    cur_vl   = '0;
    cur_vr   = '0;
    cur_mute = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (idx == IW'(i)) begin
        cur_src  = src[i*DW +: DW];
        cur_vl   = vol_l[i*VW +: VW];
        cur_vr   = vol_r[i*VW +: VW];
        cur_mute = mute[i];
      end
    end
  end

  assign p_l = cur_mute ? '0 : (PW'(cur_src) * PW'(cur_vl));
  assign p_r = cur_mute ? '0 : (PW'(cur_src) * PW'(cur_vr));

  // Slot 0 starts a fresh frame, so the old total is dropped rather than cleared.
  assign sum_l = ((idx == '0) ? '0 : acc_l) + AW'(p_l);
  assign sum_r = ((idx == '0) ? '0 : acc_r) + AW'(p_r);

  // Volume 2^(VW-1) is unity gain.
  assign shf_l = sum_l >> (VW - 1);
  assign shf_r = sum_r >> (VW - 1);
  assign sat_l = (shf_l > FULL);
  assign sat_r = (shf_r > FULL);
  assign mix_l = sat_l ? {DW{1'b1}} : shf_l[DW-1:0];
  assign mix_r = sat_r ? {DW{1'b1}} : shf_r[DW-1:0];

  // Slot counter: 0..NSRC-1 then wrap; stays at 0 when NSRC is 1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx <= '0;
    end else if (idx == LAST) begin
      idx <= '0;
    end else begin
      idx <= idx + 1'b1;
    end
  end

  // Running per-channel sum of the weighted slot products.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_l <= '0;
      acc_r <= '0;
    end else begin
      acc_l <= sum_l;
      acc_r <= sum_r;
    end
  end

  // Latch the finished frame on the last slot and pulse strobe for one clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lmix   <= '0;
      rmix   <= '0;
      clip   <= '0;
      strobe <= 1'b0;
    end else begin
      strobe <= (idx == LAST);
      if (idx == LAST) begin
        lmix <= mix_l;
        rmix <= mix_r;
        clip <= {sat_r, sat_l};
      end
    end
  end

  // First-order sigma-delta: the carry out of the low DW bits is the bitstream.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dac_l <= '0;
      dac_r <= '0;
    end else begin
      dac_l <= {1'b0, dac_l[DW-1:0]} + {1'b0, lmix};
      dac_r <= {1'b0, dac_r[DW-1:0]} + {1'b0, rmix};
    end
  end

  assign audio = {dac_r[DW], dac_l[DW]};

endmodule

// File: tb/tb_audio_mixer.sv
// Directed bench for audio_mixer (NSRC=4, DW=8, VW=4): a frame-level model
// checked every clock plus literal expectations for the key scenarios.
module tb_audio_mixer;

  localparam int NSRC = 4;
  localparam int DW   = 8;
  localparam int VW   = 4;

  // Clock and reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [NSRC*DW-1:0] src;
  logic [NSRC*VW-1:0] vol_l;
  logic [NSRC*VW-1:0] vol_r;
  logic [NSRC-1:0]    mute;
  logic [DW-1:0]      lmix;
  logic [DW-1:0]      rmix;
  logic               strobe;
  logic [1:0]         clip;
  logic [1:0]         audio;

  logic [DW-1:0] s_a  [NSRC];
  logic [VW-1:0] vl_a [NSRC];
  logic [VW-1:0] vr_a [NSRC];
  logic [NSRC-1:0] mute_v;

  int n_checks = 0;
  int n_fail   = 0;

  audio_mixer #(.NSRC(NSRC), .DW(DW), .VW(VW)) dut (
    .clock(clock), .reset(reset), .src(src), .vol_l(vol_l), .vol_r(vol_r),
    .mute(mute), .lmix(lmix), .rmix(rmix), .strobe(strobe), .clip(clip),
    .audio(audio)
  );

  // Pack the per-source stimulus arrays onto the buses.
  always_comb begin
    src   = '0;
    vol_l = '0;
    vol_r = '0;
    for (int i = 0; i < NSRC; i++) begin
      src[i*DW +: DW]   = s_a[i];
      vol_l[i*VW +: VW] = vl_a[i];
      vol_r[i*VW +: VW] = vr_a[i];
    end
    mute = mute_v;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: collect each slot's weighted products, total them at
  // the end of the frame, apply gain and saturation; DAC tracks ones-density.
  int  m_slot = 0;
  int  f_l [NSRC];
  int  f_r [NSRC];
  int  m_l = 0, m_r = 0;
  int  m_dac_l = 0, m_dac_r = 0;
  bit  m_strobe = 0;
  bit [1:0] m_clip = '0;

  always @(posedge clock or posedge reset) begin
    int tl, tr;
    if (reset) begin
      m_slot = 0; m_l = 0; m_r = 0; m_clip = '0; m_strobe = 0;
      m_dac_l = 0; m_dac_r = 0;
      for (int i = 0; i < NSRC; i++) begin f_l[i] = 0; f_r[i] = 0; end
    end else begin
      m_dac_l = (m_dac_l % 256) + m_l;
      m_dac_r = (m_dac_r % 256) + m_r;
      f_l[m_slot] = mute_v[m_slot] ? 0 : int'(s_a[m_slot]) * int'(vl_a[m_slot]);
      f_r[m_slot] = mute_v[m_slot] ? 0 : int'(s_a[m_slot]) * int'(vr_a[m_slot]);
      m_strobe = (m_slot == NSRC - 1);
      if (m_slot == NSRC - 1) begin
        tl = 0; tr = 0;
        for (int i = 0; i < NSRC; i++) begin tl += f_l[i]; tr += f_r[i]; end
        tl = tl / 8;
        tr = tr / 8;
        m_clip = {tr > 255, tl > 255};
        m_l = (tl > 255) ? 255 : tl;
        m_r = (tr > 255) ? 255 : tr;
      end
      m_slot = (m_slot + 1) % NSRC;
    end
  end

  // Compare process: every falling edge, DUT outputs against the model.
  always @(negedge clock) begin
    check("strobe", int'(strobe), int'(m_strobe));
    check("lmix", int'(lmix), m_l);
    check("rmix", int'(rmix), m_r);
    check("clip", int'(clip), int'(m_clip));
    check("audio", int'(audio), int'({m_dac_r >= 256, m_dac_l >= 256}));
  end

  // Driver tasks
  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_strobe();
    bit seen;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (strobe) begin seen = 1; break; end
    end
    #1;
    check("strobe_timeout", int'(seen), 1);
  endtask

  task automatic set_all(input logic [DW-1:0] s, input logic [VW-1:0] vl,
                         input logic [VW-1:0] vr);
    for (int i = 0; i < NSRC; i++) begin s_a[i] = s; vl_a[i] = vl; vr_a[i] = vr; end
    mute_v = '0;
  endtask

  initial begin
    int cnt;
    set_all(8'h00, 4'd0, 4'd0);

    // Reset for 3 clocks, then idle with silent sources.
    repeat (3) step();
    check("rst_lmix", int'(lmix), 0);
    check("rst_rmix", int'(rmix), 0);
    check("rst_clip", int'(clip), 0);
    check("rst_strobe", int'(strobe), 0);
    check("rst_audio", int'(audio), 0);
    reset = 1'b0;
    wait_strobe();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      cnt++;
      if (strobe) break;
    end
    #1;
    check("strobe_period", cnt, 4);
    check("idle_lmix", int'(lmix), 0);
    check("idle_audio", int'(audio), 0);

    // Single source at unity gain on the left, silent on the right.
    s_a[0] = 8'h80; vl_a[0] = 4'd8; vr_a[0] = 4'd0;
    wait_strobe(); wait_strobe();
    check("uni_lmix", int'(lmix), 'h80);
    check("uni_rmix", int'(rmix), 'h00);
    check("uni_clip", int'(clip), 0);

    // Full scale everywhere saturates both channels.
    set_all(8'hFF, 4'd15, 4'd15);
    wait_strobe(); wait_strobe();
    check("sat_lmix", int'(lmix), 'hFF);
    check("sat_rmix", int'(rmix), 'hFF);
    check("sat_clip", int'(clip), 3);
    set_all(8'hFF, 4'd1, 4'd1);
    wait_strobe(); wait_strobe();
    check("low_lmix", int'(lmix), 'h7F);
    check("low_rmix", int'(rmix), 'h7F);
    check("low_clip", int'(clip), 0);

    // Mute and un-mute source 0.
    set_all(8'h00, 4'd0, 4'd0);
    s_a[0] = 8'h80; vl_a[0] = 4'd8;
    mute_v[0] = 1'b1;
    wait_strobe(); wait_strobe();
    check("mute_lmix", int'(lmix), 'h00);
    mute_v[0] = 1'b0;
    wait_strobe(); wait_strobe();
    check("unmute_lmix", int'(lmix), 'h80);

    // DAC ones-density over 256 clocks for constant mix.
    s_a[0] = 8'h40;
    wait_strobe(); wait_strobe();
    check("dens40_lmix", int'(lmix), 'h40);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin @(negedge clock); cnt += int'(audio[0]); end
    #1;
    check("density_40", cnt, 64);
    s_a[0] = 8'hFF;
    wait_strobe(); wait_strobe();
    check("densff_lmix", int'(lmix), 'hFF);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin @(negedge clock); cnt += int'(audio[0]); end
    #1;
    check("density_ff", cnt, 255);

    // Reset in slot 2; new inputs must form the first frame after release.
    wait_strobe();
    @(negedge clock);
    @(negedge clock);
    #1;
    reset = 1'b1;
    set_all(8'h00, 4'd0, 4'd0);
    s_a[1] = 8'h20; vl_a[1] = 4'd8; vr_a[1] = 4'd4;
    #1;
    check("mid_rst_lmix", int'(lmix), 0);
    check("mid_rst_strobe", int'(strobe), 0);
    check("mid_rst_audio", int'(audio), 0);
    step();
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      #1;
      check("post_rst_strobe", int'(strobe), (i == 4) ? 1 : 0);
      if (i == 1) begin
        check("post_rst_lmix", int'(lmix), 0);
        check("post_rst_clip", int'(clip), 0);
        check("post_rst_audio", int'(audio), 0);
      end
    end
    check("post_rst_frame_l", int'(lmix), 'h20);
    check("post_rst_frame_r", int'(rmix), 'h10);

    repeat (8) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
